// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: RV32I decode plus ID/EX, EX/MEM and MEM/WB control registers for a 5-stage core.
// Revision: 1.0
`default_nettype none

module ctrl_unit_pipe #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int RESSRC_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 flush_E,
  input  logic                 Zero_E,
  input  logic                 ALUlsb_E,
  output logic [IMMSRC_W-1:0]  ImmSrc_D,
  output logic                 Illegal_D,
  output logic [ALUCTRL_W-1:0] ALUctrl_E,
  output logic                 ALUsrc_E,
  output logic                 ALUsrcA_E,
  output logic                 JumpReg_E,
  output logic                 PCsrc_E,
  output logic                 MemWrite_M,
  output logic [2:0]           MemSize_M,
  output logic                 RegWrite_M,
  output logic                 RegWrite_W,
  output logic [RESSRC_W-1:0]  ResultSrc_W
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                 reg_write;
    logic [RESSRC_W-1:0]  result_src;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 jump_reg;
    logic                 alu_src_a;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [IMMSRC_W-1:0]  imm_src;
  } dec_t;

  typedef struct packed {
    logic                 reg_write;
    logic [RESSRC_W-1:0]  result_src;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 jump_reg;
    logic                 alu_src_a;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [2:0]           funct3;
  } ex_t;

  typedef struct packed {
    logic                reg_write;
    logic [RESSRC_W-1:0] result_src;
    logic                mem_write;
    logic [2:0]          funct3;
  } mem_t;

  typedef struct packed {
    logic                reg_write;
    logic [RESSRC_W-1:0] result_src;
  } wb_t;

  dec_t dec;
  logic illegal;
  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;
  logic taken;

  // Only funct7[5] distinguishes supported encodings.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALUCTRL_W'({funct7[5], funct3});
      end
      OP_IARITH: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = (funct3 == 3'b101) ? ALUCTRL_W'({funct7[5], funct3})
                                           : ALUCTRL_W'({1'b0, funct3});
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RESSRC_W'(2'b01);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMMSRC_W'(3'b001);
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = IMMSRC_W'(3'b010);
        case (funct3)
          3'b000, 3'b001: dec.alu_ctrl = ALUCTRL_W'(4'b1000);
          3'b100, 3'b101: dec.alu_ctrl = ALUCTRL_W'(4'b0010);
          3'b110, 3'b111: dec.alu_ctrl = ALUCTRL_W'(4'b0011);
          default: begin
            dec     = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMMSRC_W'(3'b011);
        dec.result_src = RESSRC_W'(2'b11);
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm_src   = IMMSRC_W'(3'b011);
        dec.alu_src_a = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.imm_src    = IMMSRC_W'(3'b100);
        dec.result_src = RESSRC_W'(2'b10);
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec.reg_write  = 1'b1;
          dec.jump       = 1'b1;
          dec.jump_reg   = 1'b1;
          dec.alu_src    = 1'b1;
          dec.result_src = RESSRC_W'(2'b10);
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ImmSrc_D  = dec.imm_src;
  assign Illegal_D = illegal;

  // A flushed or illegal slot enters Execute as a full bubble, funct3 included.
  always_comb begin
    ex_d = '0;
    if (!flush_E && !illegal) begin
      ex_d.reg_write  = dec.reg_write;
      ex_d.result_src = dec.result_src;
      ex_d.mem_write  = dec.mem_write;
      ex_d.branch     = dec.branch;
      ex_d.jump       = dec.jump;
      ex_d.jump_reg   = dec.jump_reg;
      ex_d.alu_src_a  = dec.alu_src_a;
      ex_d.alu_src    = dec.alu_src;
      ex_d.alu_ctrl   = dec.alu_ctrl;
      ex_d.funct3     = funct3;
    end
  end

  always_comb begin
    case (ex_q.funct3)
      3'b000:         taken = Zero_E;
      3'b001:         taken = ~Zero_E;
      3'b100, 3'b110: taken = ALUlsb_E;
      3'b101, 3'b111: taken = ~ALUlsb_E;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_d            = '0;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.result_src = ex_q.result_src;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.funct3     = ex_q.funct3;
    wb_d             = '0;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ALUctrl_E   = ex_q.alu_ctrl;
  assign ALUsrc_E    = ex_q.alu_src;
  assign ALUsrcA_E   = ex_q.alu_src_a;
  assign JumpReg_E   = ex_q.jump_reg;
  assign PCsrc_E     = ex_q.jump | (ex_q.branch & taken);
  assign MemWrite_M  = mem_q.mem_write;
  assign MemSize_M   = mem_q.funct3;
  assign RegWrite_M  = mem_q.reg_write;
  assign RegWrite_W  = wb_q.reg_write;
  assign ResultSrc_W = wb_q.result_src;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_unit_pipe.sv
// Table-driven bench for ctrl_unit_pipe: back-to-back vectors tracked through D/E/M/W, plus a reset-mid-stream sequence.
`default_nettype none

module tb_ctrl_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       flush_E, Zero_E, ALUlsb_E;
  logic [2:0] ImmSrc_D;
  logic       Illegal_D;
  logic [3:0] ALUctrl_E;
  logic       ALUsrc_E, ALUsrcA_E, JumpReg_E, PCsrc_E;
  logic       MemWrite_M;
  logic [2:0] MemSize_M;
  logic       RegWrite_M, RegWrite_W;
  logic [1:0] ResultSrc_W;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_unit_pipe dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .flush_E(flush_E), .Zero_E(Zero_E), .ALUlsb_E(ALUlsb_E),
    .ImmSrc_D(ImmSrc_D), .Illegal_D(Illegal_D), .ALUctrl_E(ALUctrl_E),
    .ALUsrc_E(ALUsrc_E), .ALUsrcA_E(ALUsrcA_E), .JumpReg_E(JumpReg_E),
    .PCsrc_E(PCsrc_E), .MemWrite_M(MemWrite_M), .MemSize_M(MemSize_M),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       fl, z, l;
    logic [2:0] imm;
    logic       ill;
    logic [3:0] alu;
    logic       asrc, asrca, jr, pc;
    logic       mw;
    int         size;   // -1: not checked
    logic       rw;
    logic [1:0] rs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic fl, input logic z, input logic l,
    input logic [2:0] imm, input logic ill,
    input logic [3:0] alu, input logic asrc, input logic asrca, input logic jr, input logic pc,
    input logic mw, input int size, input logic rw, input logic [1:0] rs);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.fl = fl; v.z = z; v.l = l;
    v.imm = imm; v.ill = ill; v.alu = alu; v.asrc = asrc; v.asrca = asrca;
    v.jr = jr; v.pc = pc; v.mw = mw; v.size = size; v.rw = rw; v.rs = rs;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_d(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic fl);
    op = o; funct3 = f3; funct7 = f7; flush_E = fl;
  endtask

  initial begin
    rst_n = 1'b0; Zero_E = 1'b0; ALUlsb_E = 1'b0;
    drive_d(7'h00, 3'd0, 7'd0, 1'b0);

    //            op          f3      f7          fl z l  imm    ill alu      as aa jr pc mw sz rw rs
    tbl.push_back(mk(7'b0110011, 3'b000, 7'b0000000, 0,0,0, 3'b000,0, 4'b0000, 0,0,0,0, 0, 0,1,2'b00)); // add
    tbl.push_back(mk(7'b0110011, 3'b000, 7'b0100000, 0,0,0, 3'b000,0, 4'b1000, 0,0,0,0, 0, 0,1,2'b00)); // sub
    tbl.push_back(mk(7'b1100011, 3'b000, 7'b0000000, 0,1,0, 3'b010,0, 4'b1000, 0,0,0,1, 0, 0,0,2'b00)); // beq taken
    tbl.push_back(mk(7'b1100011, 3'b000, 7'b0000000, 0,0,0, 3'b010,0, 4'b1000, 0,0,0,0, 0, 0,0,2'b00)); // beq not
    tbl.push_back(mk(7'b1100011, 3'b101, 7'b0000000, 0,0,0, 3'b010,0, 4'b0010, 0,0,0,1, 0, 5,0,2'b00)); // bge taken
    tbl.push_back(mk(7'b1100011, 3'b110, 7'b0000000, 0,0,1, 3'b010,0, 4'b0011, 0,0,0,1, 0, 6,0,2'b00)); // bltu taken
    tbl.push_back(mk(7'b0000011, 3'b010, 7'b0000000, 1,1,1, 3'b000,0, 4'b0000, 0,0,0,0, 0, 0,0,2'b00)); // lw flushed
    tbl.push_back(mk(7'b0100011, 3'b010, 7'b0000000, 0,0,0, 3'b001,0, 4'b0000, 1,0,0,0, 1, 2,0,2'b00)); // sw
    tbl.push_back(mk(7'b1101111, 3'b000, 7'b0000000, 0,0,0, 3'b100,0, 4'b0000, 0,0,0,1, 0, 0,1,2'b10)); // jal
    tbl.push_back(mk(7'b1100111, 3'b000, 7'b0000000, 0,1,0, 3'b000,0, 4'b0000, 1,0,1,1, 0, 0,1,2'b10)); // jalr
    tbl.push_back(mk(7'b1111111, 3'b000, 7'b0000000, 0,1,1, 3'b000,1, 4'b0000, 0,0,0,0, 0,-1,0,2'b00)); // illegal op
    tbl.push_back(mk(7'b1100011, 3'b010, 7'b0000000, 0,1,1, 3'b000,1, 4'b0000, 0,0,0,0, 0,-1,0,2'b00)); // branch f3=010
    tbl.push_back(mk(7'b0110111, 3'b000, 7'b0000000, 0,0,0, 3'b011,0, 4'b0000, 0,0,0,0, 0, 0,1,2'b11)); // lui
    tbl.push_back(mk(7'b0010111, 3'b000, 7'b0000000, 0,0,0, 3'b011,0, 4'b0000, 1,1,0,0, 0, 0,1,2'b00)); // auipc
    tbl.push_back(mk(7'b0010011, 3'b101, 7'b0100000, 0,0,0, 3'b000,0, 4'b1101, 1,0,0,0, 0, 5,1,2'b00)); // srai
    tbl.push_back(mk(7'b0010011, 3'b000, 7'b0100000, 0,0,0, 3'b000,0, 4'b0000, 1,0,0,0, 0, 0,1,2'b00)); // addi, f7[5] ignored
    tbl.push_back(mk(7'b0000011, 3'b010, 7'b0000000, 0,0,0, 3'b000,0, 4'b0000, 1,0,0,0, 0, 2,1,2'b01)); // lw
    tbl.push_back(mk(7'b1100011, 3'b001, 7'b0000000, 0,0,0, 3'b010,0, 4'b1000, 0,0,0,1, 0, 1,0,2'b00)); // bne taken
    tbl.push_back(mk(7'b1100111, 3'b001, 7'b0000000, 0,1,0, 3'b000,1, 4'b0000, 0,0,0,0, 0,-1,0,2'b00)); // jalr f3!=0
    tbl.push_back(mk(7'b1100011, 3'b101, 7'b0000000, 0,0,1, 3'b010,0, 4'b0010, 0,0,0,0, 0, 5,0,2'b00)); // bge not

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ALUctrl_E", -1, ALUctrl_E, 0);
    chk("rst_PCsrc_E", -1, PCsrc_E, 0);
    chk("rst_MemWrite_M", -1, MemWrite_M, 0);
    chk("rst_RegWrite_M", -1, RegWrite_M, 0);
    chk("rst_RegWrite_W", -1, RegWrite_W, 0);
    chk("rst_ResultSrc_W", -1, ResultSrc_W, 0);
    rst_n = 1'b1;

    // Vector k sits in D during iteration k, in E during k+1, M during k+2, W during k+3.
    for (int k = 0; k < tbl.size() + 3; k++) begin
      @(negedge clk);
      if (k < tbl.size()) drive_d(tbl[k].op, tbl[k].f3, tbl[k].f7, tbl[k].fl);
      else                drive_d(7'h00, 3'd0, 7'd0, 1'b1);
      if (k >= 1 && k - 1 < tbl.size()) begin
        Zero_E = tbl[k-1].z; ALUlsb_E = tbl[k-1].l;
      end else begin
        Zero_E = 1'b0; ALUlsb_E = 1'b0;
      end
      #1;
      if (k < tbl.size()) begin
        chk("ImmSrc_D", k, ImmSrc_D, tbl[k].imm);
        chk("Illegal_D", k, Illegal_D, tbl[k].ill);
      end
      if (k >= 1 && k - 1 < tbl.size()) begin
        chk("ALUctrl_E", k-1, ALUctrl_E, tbl[k-1].alu);
        chk("ALUsrc_E", k-1, ALUsrc_E, tbl[k-1].asrc);
        chk("ALUsrcA_E", k-1, ALUsrcA_E, tbl[k-1].asrca);
        chk("JumpReg_E", k-1, JumpReg_E, tbl[k-1].jr);
        chk("PCsrc_E", k-1, PCsrc_E, tbl[k-1].pc);
      end
      if (k >= 2 && k - 2 < tbl.size()) begin
        chk("MemWrite_M", k-2, MemWrite_M, tbl[k-2].mw);
        chk("RegWrite_M", k-2, RegWrite_M, tbl[k-2].rw);
        if (tbl[k-2].size >= 0) chk("MemSize_M", k-2, MemSize_M, tbl[k-2].size);
      end
      if (k >= 3) begin
        chk("RegWrite_W", k-3, RegWrite_W, tbl[k-3].rw);
        chk("ResultSrc_W", k-3, ResultSrc_W, tbl[k-3].rs);
      end
    end

    // Reset mid-stream: add, add, sw in flight and jal in D when reset hits.
    @(negedge clk); drive_d(7'b0110011, 3'b000, 7'd0, 1'b0); Zero_E = 1'b0; ALUlsb_E = 1'b0;
    @(negedge clk); drive_d(7'b0110011, 3'b000, 7'd0, 1'b0);
    @(negedge clk); drive_d(7'b0100011, 3'b010, 7'd0, 1'b0);
    @(negedge clk); drive_d(7'b1101111, 3'b000, 7'd0, 1'b0);
    #1;
    chk("pre_rst_MemWrite_E_is_sw", 100, ALUsrc_E, 1);
    chk("pre_rst_RegWrite_W", 100, RegWrite_W, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_MemWrite_M", 101, MemWrite_M, 0);
    chk("midrst_RegWrite_M", 101, RegWrite_M, 0);
    chk("midrst_RegWrite_W", 101, RegWrite_W, 0);
    chk("midrst_PCsrc_E", 101, PCsrc_E, 0);
    chk("midrst_ALUsrc_E", 101, ALUsrc_E, 0);
    drive_d(7'b0110011, 3'b000, 7'd0, 1'b1);
    @(negedge clk); #1;
    chk("postrst_MemWrite_M", 102, MemWrite_M, 0);
    chk("postrst_RegWrite_W", 102, RegWrite_W, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Pipelined RV32I control unit for the 5-stage core (F/D/E/M/W). It decodes op/funct3/funct7 in Decode and carries the control word through the ID/EX, EX/MEM and MEM/WB registers. It resolves branches and jumps in Execute. It also supports bubble insertion from the hazard unit and adds U/J-type and illegal-instruction decode.

Parameters:
ALUCTRL_W, 4, ALU control width; encoding is {bit3, funct3}.
IMMSRC_W, 3, ext_unit immediate selector width (I/S/B/U/J).
RESSRC_W, 2, writeback mux selector width.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
op  in  7  instr[6:0], Decode stage
funct3  in  3  instr[14:12], Decode stage
funct7  in  7  instr[31:25], Decode stage
flush_E  in  1  hazard unit: load ID/EX with a bubble
Zero_E  in  1  ALU result==0, Execute stage
ALUlsb_E  in  1  ALU result bit 0 (slt/sltu), Execute stage
ImmSrc_D  out  IMMSRC_W  I=000, S=001, B=010, U=011, J=100
Illegal_D  out  1  unsupported encoding in Decode
ALUctrl_E  out  ALUCTRL_W  ALU operation
ALUsrc_E  out  1  operand B: 0=RD2, 1=ImmExt
ALUsrcA_E  out  1  operand A: 0=RD1, 1=PC (auipc)
JumpReg_E  out  1  target = ALU result (jalr), else PC+ImmExt
PCsrc_E  out  1  redirect fetch (combinational from E regs)
MemWrite_M  out  1  data memory write enable
MemSize_M  out  3  funct3 of load/store
RegWrite_M  out  1  forwarding-unit visibility
RegWrite_W  out  1  register file write enable
ResultSrc_W  out  RESSRC_W  00=ALU, 01=mem, 10=PC+4, 11=ImmExt

Behaviour:
- Decode is combinational on op/funct3/funct7. Fields are {RegWrite, ResultSrc, MemWrite, Branch, Jump, JumpReg, ALUsrcA, ALUsrc, ALUctrl, ImmSrc}. Unlisted fields are 0.
- R 0110011: RegWrite=1, ALUctrl={funct7[5],funct3}.
- I-arith 0010011: RegWrite=1, ALUsrc=1, ImmSrc=000. ALUctrl={funct7[5],funct3} when funct3==101, else {0,funct3}.
- Load 0000011: RegWrite=1, ALUsrc=1, ResultSrc=01, ALUctrl=0000.
- Store 0100011: MemWrite=1, ALUsrc=1, ImmSrc=001, ALUctrl=0000.
- Branch 1100011: Branch=1, ImmSrc=010.
  - beq/bne: ALUctrl=1000 (sub).
  - blt/bge: ALUctrl=0010 (slt).
  - bltu/bgeu: ALUctrl=0011 (sltu).
  - funct3 010 or 011 is illegal.
- LUI 0110111: RegWrite=1, ImmSrc=011, ResultSrc=11.
- AUIPC 0010111: RegWrite=1, ImmSrc=011, ALUsrcA=1, ALUsrc=1, ALUctrl=0000.
- JAL 1101111: RegWrite=1, Jump=1, ImmSrc=100, ResultSrc=10.
- JALR 1100111 with funct3==000: RegWrite=1, Jump=1, JumpReg=1, ALUsrc=1, ALUctrl=0000, ResultSrc=10.
- Any other encoding: Illegal_D=1 and the control word is all-zero (a bubble).
- ID/EX register captures the decode word plus funct3 on every clk edge.
  - On !rst_n or flush_E it captures an all-zero word.
  - flush_E has priority over a valid decode.
- EX/MEM captures {RegWrite, ResultSrc, MemWrite, funct3}. MEM/WB captures {RegWrite, ResultSrc}. Neither has a stall. Both zero on !rst_n.
- Branch condition in E (taken):
  - beq: Zero_E.
  - bne: ~Zero_E.
  - blt/bltu: ALUlsb_E.
  - bge/bgeu: ~ALUlsb_E.
- PCsrc_E = Jump_E | (Branch_E & taken). It is 0 whenever the ID/EX register holds a bubble.
- Latency: decode to E outputs 1 cycle, to M 2 cycles, to W 3 cycles.
- Reset mid-stream: all stage registers clear on the same edge. Every output except ImmSrc_D/Illegal_D reads 0 the following cycle, with no partial writes.
- The block never writes a register on a bubble. RegWrite and MemWrite are 0 for any flushed or illegal slot.

Test Plan:
- add x3,x1,x2 (op=0110011,f3=000,f7=0000000) then sub (f7=0100000) -> ALUctrl_E=0000 then 1000; RegWrite_W=1 3 cycles after each decode; ResultSrc_W=00.
- beq with Zero_E=1 -> PCsrc_E=1. Same with Zero_E=0 -> 0. bge with ALUlsb_E=0 -> PCsrc_E=1, ALUctrl_E=0010. bltu -> ALUctrl_E=0011.
- lw followed by flush_E=1 in the same cycle -> ID/EX bubble. Next cycle: ALUctrl_E=0, PCsrc_E=0, and 2 cycles later RegWrite_W=0 and MemWrite_M=0.
- jal, then jalr -> PCsrc_E=1 regardless of Zero_E. JumpReg_E=0 then 1. ResultSrc_W=10 for both.
- op=1111111 and branch f3=010 -> Illegal_D=1, no RegWrite/MemWrite/PCsrc downstream.
- sw in flight (MemWrite_M due next cycle) with rst_n=0 held 1 cycle -> MemWrite_M=0, RegWrite_W=0, PCsrc_E=0 after the edge.
